// File: rtl/btn_pkg.sv
// Shared state encoding for the push-button conditioning chain
// (debouncer and button-press FSM).
package btn_pkg;

  typedef enum logic [1:0] {
    ST_LOW       = 2'd0,
    ST_RISE_WAIT = 2'd1,
    ST_HIGH      = 2'd2,
    ST_FALL_WAIT = 2'd3
  } btn_state_e;

endpackage

// File: rtl/btn_sync.sv
// 1-bit two-flop synchroniser for an asynchronous input; both flops reset to 0.
module btn_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Next-value logic for the two-stage shift.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchroniser flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/btn_debounce.sv
// Push-button debouncer: accepts a level after STABLE_CYCLES identical samples.
// Define BTN_DEBOUNCE_SYNC_EN to put a 2-flop synchroniser in front of the FSM.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic b_raw,
  output logic b_clean,
  output logic b_rise,
  output logic b_fall
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CYCLES - 1);

  logic sample;

`ifdef BTN_DEBOUNCE_SYNC_EN
  btn_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (b_raw),
    .q   (sample)
  );
`else
  assign sample = b_raw;
`endif

  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             b_clean_q, b_clean_d;
  logic             b_rise_q, b_rise_d;
  logic             b_fall_q, b_fall_d;

  // Next-state, counter and registered-output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    b_clean_d = b_clean_q;
    b_rise_d  = 1'b0;
    b_fall_d  = 1'b0;
    case (state_q)
      ST_LOW: begin
        b_clean_d = 1'b0;
        if (sample) begin
          state_d = ST_RISE_WAIT;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d   = '0;
        end
      end
      ST_RISE_WAIT: begin
        b_clean_d = 1'b0;
        if (!sample) begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end else if (cnt_q == LAST_CNT) begin
          state_d   = ST_HIGH;
          cnt_d     = '0;
          b_clean_d = 1'b1;
          b_rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HIGH: begin
        b_clean_d = 1'b1;
        if (!sample) begin
          state_d = ST_FALL_WAIT;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d   = '0;
        end
      end
      ST_FALL_WAIT: begin
        b_clean_d = 1'b1;
        if (sample) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == LAST_CNT) begin
          state_d   = ST_LOW;
          cnt_d     = '0;
          b_clean_d = 1'b0;
          b_fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        // Unreachable with a full 2-bit enum; kept as a safe recovery path.
        state_d   = ST_LOW;
        cnt_d     = '0;
        b_clean_d = 1'b0;
      end
    endcase
  end

  // State, counter and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_LOW;
      cnt_q     <= '0;
      b_clean_q <= 1'b0;
      b_rise_q  <= 1'b0;
      b_fall_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      b_clean_q <= b_clean_d;
      b_rise_q  <= b_rise_d;
      b_fall_q  <= b_fall_d;
    end
  end

  assign b_clean = b_clean_q;
  assign b_rise  = b_rise_q;
  assign b_fall  = b_fall_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Testbench for btn_debounce: directed scenarios with literal expectations plus
// randomized bouncing input checked every cycle against a run-length model.
module tb_btn_debounce;

  localparam int STABLE = 4;
`ifdef BTN_DEBOUNCE_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic b_raw = 1'b0;
  logic b_clean, b_rise, b_fall;

  int errors = 0;
  int checks = 0;
  logic cmp_en = 1'b0;

  // Reference model state.
  logic m_clean = 1'b0, m_rise = 1'b0, m_fall = 1'b0;
  logic m_p1 = 1'b0, m_p2 = 1'b0;
  int   m_run = 0;

  btn_debounce #(.STABLE_CYCLES(STABLE), .CNT_W(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .b_raw   (b_raw),
    .b_clean (b_clean),
    .b_rise  (b_rise),
    .b_fall  (b_fall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: the clean level flips once STABLE consecutive samples disagree with it.
  always @(posedge clk) begin : model
    logic s;
    int   r;
    if (rst) begin
      m_clean <= 1'b0; m_rise <= 1'b0; m_fall <= 1'b0;
      m_run   <= 0;    m_p1   <= 1'b0; m_p2   <= 1'b0;
    end else begin
      s = (LAT != 0) ? m_p2 : b_raw;
      m_p1 <= b_raw;
      m_p2 <= m_p1;
      r = (s != m_clean) ? m_run + 1 : 0;
      if (r == STABLE) begin
        m_clean <= s;
        m_rise  <= s;
        m_fall  <= ~s;
        r = 0;
      end else begin
        m_rise <= 1'b0;
        m_fall <= 1'b0;
      end
      m_run <= r;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_clean", b_clean, m_clean);
      chk("model_rise", b_rise, m_rise);
      chk("model_fall", b_fall, m_fall);
      chk("rise_and_fall", b_rise & b_fall, 1'b0);
    end
  end

  initial begin
    int hold;
    int bounce_pct;

    rst = 1'b1;
    b_raw = 1'b0;
    step();
    step();
    cmp_en = 1'b1;
    chk("reset_clean", b_clean, 1'b0);
    chk("reset_rise", b_rise, 1'b0);
    chk("reset_fall", b_fall, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step();

    // Scenario 1: clean rising edge.
    b_raw = 1'b1;
    for (int i = 0; i < STABLE - 1 + LAT; i++) begin
      step();
      chk("s1_wait_clean", b_clean, 1'b0);
      chk("s1_wait_rise", b_rise, 1'b0);
    end
    step();
    chk("s1_accept_clean", b_clean, 1'b1);
    chk("s1_accept_rise", b_rise, 1'b1);
    step();
    chk("s1_after_rise", b_rise, 1'b0);
    chk("s1_after_clean", b_clean, 1'b1);
    chk("s1_no_fall", b_fall, 1'b0);
    for (int i = 0; i < 4; i++) step();

    // Scenario 4: falling with a 0,1 bounce: pattern 0,1,0,0,0,0.
    b_raw = 1'b0; step();
    b_raw = 1'b1; step();
    b_raw = 1'b0;
    for (int i = 2; i < 5 + LAT; i++) begin
      step();
      chk("s4_wait_clean", b_clean, 1'b1);
      chk("s4_wait_fall", b_fall, 1'b0);
    end
    step();
    chk("s4_accept_clean", b_clean, 1'b0);
    chk("s4_accept_fall", b_fall, 1'b1);
    step();
    chk("s4_after_fall", b_fall, 1'b0);
    for (int i = 0; i < 4; i++) step();

    // Scenario 2: a 3-edge glitch is rejected.
    b_raw = 1'b1;
    for (int i = 0; i < 3; i++) step();
    b_raw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("s2_clean", b_clean, 1'b0);
      chk("s2_rise", b_rise, 1'b0);
    end

    // Scenario 3: pattern 1,0,1,1,1,1 accepted on edge 5 only.
    b_raw = 1'b1; step();
    b_raw = 1'b0; step();
    b_raw = 1'b1;
    for (int i = 2; i < 5 + LAT; i++) begin
      step();
      chk("s3_wait_clean", b_clean, 1'b0);
    end
    step();
    chk("s3_accept_clean", b_clean, 1'b1);
    chk("s3_accept_rise", b_rise, 1'b1);
    b_raw = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("s3_back_low", b_clean, 1'b0);

    // Scenario 5: reset in mid-count abandons the candidate.
    b_raw = 1'b1;
    for (int i = 0; i < 2 + LAT; i++) step();
    rst = 1'b1;
    step();
    chk("s5_rst_clean", b_clean, 1'b0);
    chk("s5_rst_rise", b_rise, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < STABLE - 1 + LAT; i++) begin
      step();
      chk("s5_wait_clean", b_clean, 1'b0);
    end
    step();
    chk("s5_accept_clean", b_clean, 1'b1);
    chk("s5_accept_rise", b_rise, 1'b1);

    // Reset while high: clean drops with no fall pulse.
    step();
    rst = 1'b1;
    step();
    chk("rst_high_clean", b_clean, 1'b0);
    chk("rst_high_fall", b_fall, 1'b0);
    rst = 1'b0;
    b_raw = 1'b0;
    for (int i = 0; i < 4; i++) step();

    // Randomized bouncing input at several bounce densities.
    for (int seg = 0; seg < 3; seg++) begin
      for (int n = 0; n < 1000; n++) begin
        bounce_pct = 10 + seg * 30;
        if ($urandom_range(99, 0) < bounce_pct) begin
          hold = $urandom_range(3, 1);
        end else begin
          hold = $urandom_range(STABLE + 4, STABLE - 1);
        end
        b_raw = $urandom_range(1, 0) != 0;
        rst = ($urandom_range(199, 0) == 0);
        step();
        rst = 1'b0;
        for (int h = 1; h < hold; h++) step();
      end
    end

    step();
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/btn_debounce.md
# btn_debounce

Front-end conditioner for a raw push-button input. It optionally synchronises the asynchronous pin, then requires STABLE_CYCLES consecutive identical samples before changing its clean output level. It produces a debounced level b_clean, which feeds the button-press FSM's b input directly, and registers one-cycle rise and fall pulses for other consumers.

## Interface
- STABLE_CYCLES, default 4: number of consecutive identical samples needed to accept a level change. Legal range is 2 to 2^CNT_W−1. Use a small value in sim and a large one on the board.
- CNT_W, default 16: width of the stability counter.
- clk  input  1  system clock; all logic is rising-edge.
- rst  input  1  synchronous, active-high reset.
- b_raw  input  1  raw button pin; may bounce and is asynchronous to clk.
- b_clean  output  1  debounced level, registered.
- b_rise  output  1  one-cycle pulse, registered, on an accepted 0→1 change.
- b_fall  output  1  one-cycle pulse, registered, on an accepted 1→0 change.

## Operation
- Sample path: `sample` is the value the FSM evaluates each edge. Its source depends on the configuration macro.
- States:
  - ST_LOW: b_clean=0.
  - ST_RISE_WAIT: candidate high.
  - ST_HIGH: b_clean=1.
  - ST_FALL_WAIT: candidate low.
- ST_LOW:
  - sample=1 → ST_RISE_WAIT, cnt←1.
  - Otherwise stay, cnt←0.
- ST_RISE_WAIT:
  - sample=0 → ST_LOW, cnt←0. A bounce fully restarts the count.
  - sample=1 and cnt==STABLE_CYCLES−1 → ST_HIGH, cnt←0, b_clean←1, b_rise←1.
  - Otherwise cnt←cnt+1.
- ST_HIGH / ST_FALL_WAIT: mirror of the two rules above with sample inverted. Entry into ST_LOW from ST_FALL_WAIT sets b_clean←0 and b_fall←1.
- b_rise and b_fall are 0 on every edge except the accepting edge. They are never high together.
- Counter arithmetic:
  - Unsigned, CNT_W bits.
  - Never exceeds STABLE_CYCLES−1, so no wrap is possible.
  - Compare is equality against STABLE_CYCLES−1, truncated to CNT_W.
- An illegal state encoding recovers to ST_LOW with cnt=0 and all outputs 0.

## Timing
- Reset values: state=ST_LOW, cnt=0, b_clean=0, b_rise=0, b_fall=0, synchroniser flops=0.
- Reset mid-count abandons the candidate. After rst deasserts, a fresh STABLE_CYCLES run is required.
- Rst asserted while in ST_HIGH forces b_clean=0 on that edge and produces no b_fall pulse.
- Acceptance latency: sample must equal the new level on STABLE_CYCLES consecutive edges. b_clean changes on the last of those edges.
- Latency from b_raw without the macro: if b_raw is first high before edge k and held, b_clean and b_rise are high after edge k+STABLE_CYCLES−1.
- With the macro, add 2 edges.
- b_rise and b_fall last exactly one clk cycle.
- Minimum spacing between accepted changes is STABLE_CYCLES edges.

## Configuration
- BTN_DEBOUNCE_SYNC_EN defined:
  - b_raw passes through a 2-flop synchroniser, and `sample` is the second flop.
  - Adds 2 cycles of latency.
  - Required for real pins.
- BTN_DEBOUNCE_SYNC_EN undefined:
  - `sample` is b_raw directly, with no added latency.
  - For sim, or for inputs already synchronous to clk.
- Port list is identical in both builds.

## Structure
- Shared package btn_pkg holds:
  - The 2-bit state localparams ST_LOW=0, ST_RISE_WAIT=1, ST_HIGH=2, ST_FALL_WAIT=3.
  - A state typedef, shared with the button-press FSM's package.
- Sub-module btn_sync: 1-bit 2-flop synchroniser with clk, rst, d, q; reset value 0. It is instantiated only under BTN_DEBOUNCE_SYNC_EN.

## Test plan
All scenarios use STABLE_CYCLES=4.
1. Macro off; b_raw 0→1 before edge 0 and held → b_clean=1 and b_rise=1 after edge 3; b_rise=0 after edge 4; b_fall never asserts.
2. Macro off; b_raw high for 3 edges then low → b_clean stays 0; b_rise never asserts; state returns to ST_LOW.
3. Macro off; b_raw pattern 1,0,1,1,1,1 on edges 0–5 → b_clean=1 after edge 5 only; exactly one b_rise pulse.
4. From ST_HIGH, b_raw 1→0 held → b_fall pulse and b_clean=0 after the 4th low edge; bounce 0,1 during the wait restarts the count.
5. rst=1 for one edge during ST_RISE_WAIT at cnt=2, b_raw held high → all outputs 0; b_clean rises 4 edges after rst deasserts.
6. Macro on; repeat scenario 1 → b_clean and b_rise high after edge 5 (2 cycles later).
